// File: rtl/square_channel_sequencer.sv
// Square-channel control: frame-step sequencer driving length, envelope and sweep.
// Produces registered frequency, duty, volume and enable for the tone generator.
module square_channel_sequencer #(
    parameter int LENGTH_MAX = 64
) (
    input  logic        I_BITCLK,
    input  logic        I_RESET,
    input  logic        I_FRAME_TICK,
    input  logic        I_TRIGGER,
    input  logic        I_FREQ_WRITE,
    input  logic [10:0] I_FREQUENCY,
    input  logic [1:0]  I_DUTY_CYCLE,
    input  logic        I_LENGTH_WRITE,
    input  logic [5:0]  I_LENGTH_LOAD,
    input  logic        I_LENGTH_EN,
    input  logic [3:0]  I_ENV_INIT,
    input  logic        I_ENV_UP,
    input  logic [2:0]  I_ENV_PERIOD,
    input  logic [2:0]  I_SWEEP_PERIOD,
    input  logic        I_SWEEP_DOWN,
    input  logic [2:0]  I_SWEEP_SHIFT,
    output logic [10:0] O_FREQUENCY,
    output logic [1:0]  O_DUTY_CYCLE,
    output logic [3:0]  O_VOLUME,
    output logic        O_WAVEFORM_EN
);

    localparam int LW = $clog2(LENGTH_MAX + 1);

    logic [2:0]    step;
    logic [LW-1:0] length;
    logic [2:0]    env_timer;
    logic [3:0]    sweep_timer;
    logic [10:0]   shadow;
    logic          sweep_en;

    logic          length_clk;
    logic          sweep_clk;
    logic          env_clk;
    logic          dac_on;
    logic          trig_ovf;
    logic          sw_ovf2;
    logic [11:0]   sw_new;
    logic [LW-1:0] len_wr;
    logic [3:0]    sweep_reload;

    function automatic logic [11:0] sweep_calc(
        input logic [10:0] f,
        input logic        down,
        input logic [2:0]  sh
    );
        logic [11:0] d;
        d = {1'b0, f >> sh};
        return down ? ({1'b0, f} - d) : ({1'b0, f} + d);
    endfunction

    function automatic logic sweep_ovf(
        input logic [10:0] f,
        input logic        down,
        input logic [2:0]  sh
    );
        logic [11:0] n;
        n = sweep_calc(f, down, sh);
        return n[11];
    endfunction

    always_comb begin
        length_clk   = I_FRAME_TICK & ~step[0];
        sweep_clk    = I_FRAME_TICK & (step[1:0] == 2'b10);
        env_clk      = I_FRAME_TICK & (step == 3'd7);
        dac_on       = (I_ENV_INIT != 4'd0) | I_ENV_UP;
        trig_ovf     = sweep_ovf(O_FREQUENCY, I_SWEEP_DOWN, I_SWEEP_SHIFT);
        sw_new       = sweep_calc(shadow, I_SWEEP_DOWN, I_SWEEP_SHIFT);
        sw_ovf2      = sweep_ovf(sw_new[10:0], I_SWEEP_DOWN, I_SWEEP_SHIFT);
        len_wr       = LW'(LENGTH_MAX) - LW'(I_LENGTH_LOAD);
        sweep_reload = (I_SWEEP_PERIOD == 3'd0) ? 4'd8 : {1'b0, I_SWEEP_PERIOD};
    end

    always_ff @(posedge I_BITCLK) begin
        if (I_RESET) begin
            step          <= '0;
            length        <= '0;
            env_timer     <= '0;
            sweep_timer   <= '0;
            shadow        <= '0;
            sweep_en      <= 1'b0;
            O_FREQUENCY   <= '0;
            O_DUTY_CYCLE  <= '0;
            O_VOLUME      <= '0;
            O_WAVEFORM_EN <= 1'b0;
        end else begin
            O_DUTY_CYCLE <= I_DUTY_CYCLE;
            if (I_FRAME_TICK) begin
                step <= step + 3'd1;
            end
            if (I_TRIGGER) begin
                O_WAVEFORM_EN <= dac_on;
                if (I_LENGTH_WRITE) begin
                    length <= (len_wr == '0) ? LW'(LENGTH_MAX) : len_wr;
                end else if (length == '0) begin
                    length <= LW'(LENGTH_MAX);
                end
                O_VOLUME    <= I_ENV_INIT;
                env_timer   <= I_ENV_PERIOD;
                shadow      <= O_FREQUENCY;
                sweep_timer <= sweep_reload;
                sweep_en    <= (I_SWEEP_PERIOD != 3'd0) | (I_SWEEP_SHIFT != 3'd0);
                if (I_SWEEP_SHIFT != 3'd0 && trig_ovf) begin
                    O_WAVEFORM_EN <= 1'b0;
                end
            end else begin
                if (I_LENGTH_WRITE) begin
                    length <= len_wr;
                end else if (length_clk && I_LENGTH_EN && length != '0) begin
                    length <= length - LW'(1);
                    if (length == LW'(1)) begin
                        O_WAVEFORM_EN <= 1'b0;
                    end
                end
                if (env_clk && I_ENV_PERIOD != 3'd0) begin
                    if (env_timer <= 3'd1) begin
                        env_timer <= I_ENV_PERIOD;
                        if (I_ENV_UP && O_VOLUME != 4'd15) begin
                            O_VOLUME <= O_VOLUME + 4'd1;
                        end else if (!I_ENV_UP && O_VOLUME != 4'd0) begin
                            O_VOLUME <= O_VOLUME - 4'd1;
                        end
                    end else begin
                        env_timer <= env_timer - 3'd1;
                    end
                end
                // an already-zero timer counts as expired
                if (sweep_clk) begin
                    if (sweep_timer <= 4'd1) begin
                        sweep_timer <= sweep_reload;
                        if (sweep_en && I_SWEEP_PERIOD != 3'd0) begin
                            if (sw_new[11]) begin
                                O_WAVEFORM_EN <= 1'b0;
                            end else if (I_SWEEP_SHIFT != 3'd0) begin
                                shadow      <= sw_new[10:0];
                                O_FREQUENCY <= sw_new[10:0];
                                if (sw_ovf2) begin
                                    O_WAVEFORM_EN <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        sweep_timer <= sweep_timer - 4'd1;
                    end
                end
            end
            if (I_FREQ_WRITE) begin
                O_FREQUENCY <= I_FREQUENCY;
            end
            if (!dac_on) begin
                O_WAVEFORM_EN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_square_channel_sequencer.sv
// Bench for square_channel_sequencer: vector table, corner sequences,
// and random traffic against an arithmetic reference model.
module tb_square_channel_sequencer;

    localparam int LMAX = 64;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        trig;
    logic        fwr;
    logic [10:0] freq;
    logic [1:0]  duty;
    logic        lwr;
    logic [5:0]  lload;
    logic        len_en;
    logic [3:0]  einit;
    logic        eup;
    logic [2:0]  eper;
    logic [2:0]  sper;
    logic        sdown;
    logic [2:0]  sshift;
    logic [10:0] o_freq;
    logic [1:0]  o_duty;
    logic [3:0]  o_vol;
    logic        o_en;

    square_channel_sequencer #(.LENGTH_MAX(LMAX)) dut (
        .I_BITCLK(clk),
        .I_RESET(rst),
        .I_FRAME_TICK(tick),
        .I_TRIGGER(trig),
        .I_FREQ_WRITE(fwr),
        .I_FREQUENCY(freq),
        .I_DUTY_CYCLE(duty),
        .I_LENGTH_WRITE(lwr),
        .I_LENGTH_LOAD(lload),
        .I_LENGTH_EN(len_en),
        .I_ENV_INIT(einit),
        .I_ENV_UP(eup),
        .I_ENV_PERIOD(eper),
        .I_SWEEP_PERIOD(sper),
        .I_SWEEP_DOWN(sdown),
        .I_SWEEP_SHIFT(sshift),
        .O_FREQUENCY(o_freq),
        .O_DUTY_CYCLE(o_duty),
        .O_VOLUME(o_vol),
        .O_WAVEFORM_EN(o_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit rst, tick, trig, fwr;
        int freq, duty;
        bit lwr;
        int lload;
        bit len_en;
        int einit;
        bit eup;
        int eper, sper;
        bit sdown;
        int sshift;
    } in_t;

    typedef struct {
        in_t i;
        int  f, d, v, e;
    } vec_t;

    int checks;
    int failures;
    in_t base;
    vec_t vecs[10];

    // reference model state
    int m_step, m_len, m_envt, m_swt, m_shadow, m_freq, m_duty, m_vol;
    bit m_swen, m_en;

    function automatic in_t idle();
        in_t v;
        v = '{default: 0};
        return v;
    endfunction

    function automatic int sweep_next(int s, bit down, int sh);
        int delta;
        delta = s / (1 << sh);
        return down ? s - delta : s + delta;
    endfunction

    task automatic model(in_t v);
        bit lclk, sclk, eclk, dac;
        int l, n, old_f;
        if (v.rst) begin
            m_step = 0; m_len = 0; m_envt = 0; m_swt = 0; m_shadow = 0;
            m_swen = 0; m_freq = 0; m_duty = 0; m_vol = 0; m_en = 0;
            return;
        end
        lclk = v.tick && (m_step % 2 == 0);
        sclk = v.tick && (m_step == 2 || m_step == 6);
        eclk = v.tick && (m_step == 7);
        dac = (v.einit != 0) || v.eup;
        old_f = m_freq;
        m_duty = v.duty;
        if (v.trig) begin
            m_en = dac;
            l = v.lwr ? LMAX - v.lload : m_len;
            m_len = (l == 0) ? LMAX : l;
            m_vol = v.einit;
            m_envt = v.eper;
            m_shadow = old_f;
            m_swt = (v.sper == 0) ? 8 : v.sper;
            m_swen = (v.sper != 0) || (v.sshift != 0);
            if (v.sshift != 0 && sweep_next(old_f, v.sdown, v.sshift) > 2047)
                m_en = 0;
        end else begin
            if (v.lwr) m_len = LMAX - v.lload;
            else if (lclk && v.len_en && m_len > 0) begin
                m_len = m_len - 1;
                if (m_len == 0) m_en = 0;
            end
            if (eclk && v.eper != 0) begin
                if (m_envt - 1 <= 0) begin
                    m_envt = v.eper;
                    if (v.eup && m_vol < 15) m_vol = m_vol + 1;
                    else if (!v.eup && m_vol > 0) m_vol = m_vol - 1;
                end else m_envt = m_envt - 1;
            end
            if (sclk) begin
                if (m_swt - 1 <= 0) begin
                    m_swt = (v.sper == 0) ? 8 : v.sper;
                    if (m_swen && v.sper != 0) begin
                        n = sweep_next(m_shadow, v.sdown, v.sshift);
                        if (n > 2047) m_en = 0;
                        else if (v.sshift != 0) begin
                            m_shadow = n;
                            m_freq = n;
                            if (sweep_next(n, v.sdown, v.sshift) > 2047) m_en = 0;
                        end
                    end
                end else m_swt = m_swt - 1;
            end
        end
        if (v.fwr) m_freq = v.freq;
        if (!dac) m_en = 0;
        if (v.tick) m_step = (m_step + 1) % 8;
    endtask

    task automatic run(in_t v);
        rst = v.rst; tick = v.tick; trig = v.trig; fwr = v.fwr;
        freq = 11'(v.freq); duty = 2'(v.duty); lwr = v.lwr;
        lload = 6'(v.lload); len_en = v.len_en; einit = 4'(v.einit);
        eup = v.eup; eper = 3'(v.eper); sper = 3'(v.sper);
        sdown = v.sdown; sshift = 3'(v.sshift);
        @(posedge clk);
        #1;
        model(v);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, int f, int d, int v, int e);
        chk({name, ".freq"}, int'(o_freq), f);
        chk({name, ".duty"}, int'(o_duty), d);
        chk({name, ".vol"}, int'(o_vol), v);
        chk({name, ".en"}, int'(o_en), e);
    endtask

    task automatic cyc(bit t, bit tr);
        in_t v;
        v = base;
        v.tick = t;
        v.trig = tr;
        run(v);
    endtask

    task automatic tick2();
        cyc(1, 0);
        cyc(0, 0);
    endtask

    task automatic do_reset();
        in_t v;
        v = base;
        v.rst = 1;
        run(v);
    endtask

    function automatic vec_t mkv(bit r, bit tr, bit fw, int f, int d,
                                 int ei, bit eu, int sh, bit dn,
                                 int ef, int ed, int ev, int ee);
        vec_t x;
        x.i = idle();
        x.i.rst = r; x.i.trig = tr; x.i.fwr = fw; x.i.freq = f;
        x.i.duty = d; x.i.einit = ei; x.i.eup = eu;
        x.i.sshift = sh; x.i.sdown = dn;
        x.f = ef; x.d = ed; x.v = ev; x.e = ee;
        return x;
    endfunction

    initial begin
        in_t v;
        checks = 0;
        failures = 0;
        base = idle();

        vecs[0] = mkv(1, 0, 0, 'h555, 3, 7, 1, 0, 0, 0, 0, 0, 0);
        vecs[1] = mkv(0, 0, 1, 'h123, 2, 0, 0, 0, 0, 'h123, 2, 0, 0);
        vecs[2] = mkv(0, 1, 0, 0, 2, 0, 0, 0, 0, 'h123, 2, 0, 0);
        vecs[3] = mkv(0, 1, 0, 0, 1, 9, 0, 0, 0, 'h123, 1, 9, 1);
        vecs[4] = mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h123, 1, 9, 0);
        vecs[5] = mkv(0, 1, 0, 0, 3, 0, 1, 0, 0, 'h123, 3, 0, 1);
        vecs[6] = mkv(0, 0, 1, 'h7FF, 3, 0, 1, 0, 0, 'h7FF, 3, 0, 1);
        vecs[7] = mkv(0, 1, 0, 0, 3, 5, 0, 1, 0, 'h7FF, 3, 5, 0);
        vecs[8] = mkv(0, 1, 0, 0, 3, 5, 0, 1, 1, 'h7FF, 3, 5, 1);
        vecs[9] = mkv(1, 1, 1, 'h3FF, 2, 15, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            run(vecs[k].i);
            chk_all($sformatf("vec%0d", k), vecs[k].f, vecs[k].d,
                    vecs[k].v, vecs[k].e);
        end

        // length expiry: load 62 -> two length clocks
        base = idle(); base.einit = 15; base.len_en = 1;
        do_reset();
        v = base; v.trig = 1; v.lwr = 1; v.lload = 62;
        run(v);
        chk("len.trig_en", int'(o_en), 1);
        tick2();
        chk("len.clk1_en", int'(o_en), 1);
        tick2();
        chk("len.step1_en", int'(o_en), 1);
        tick2();
        chk("len.clk2_en", int'(o_en), 0);

        // envelope ramp down
        base = idle(); base.einit = 15; base.eper = 1;
        do_reset();
        cyc(0, 1);
        chk("env.start", int'(o_vol), 15);
        for (int k = 1; k <= 17; k++) begin
            for (int t = 0; t < 7; t++) tick2();
            if (k == 1) chk("env.hold", int'(o_vol), 15);
            tick2();
            chk($sformatf("env.k%0d", k), int'(o_vol), (15 - k < 0) ? 0 : 15 - k);
        end
        chk("env.en", int'(o_en), 1);

        // sweep up 0x400 -> 0x600, then overflow
        base = idle(); base.einit = 15; base.sper = 1; base.sshift = 1;
        do_reset();
        v = base; v.fwr = 1; v.freq = 'h400;
        run(v);
        cyc(0, 1);
        chk("sw.trig_en", int'(o_en), 1);
        chk("sw.trig_f", int'(o_freq), 'h400);
        repeat (3) tick2();
        chk("sw.clk1_f", int'(o_freq), 'h600);
        chk("sw.clk1_en", int'(o_en), 0);
        repeat (4) tick2();
        chk("sw.clk2_f", int'(o_freq), 'h600);
        chk("sw.clk2_en", int'(o_en), 0);

        // reset in the middle of a sweep
        base = idle(); base.einit = 15; base.sper = 1; base.sshift = 2;
        base.duty = 3;
        do_reset();
        v = base; v.fwr = 1; v.freq = 'h100;
        run(v);
        cyc(0, 1);
        repeat (3) tick2();
        chk("rs.pre_f", int'(o_freq), 'h140);
        chk("rs.pre_en", int'(o_en), 1);
        tick2();
        v = base; v.rst = 1; v.tick = 1; v.trig = 1;
        run(v);
        chk_all("rs.post", 0, 0, 0, 0);
        base.sper = 0; base.sshift = 0; base.len_en = 1;
        v = base; v.trig = 1; v.lwr = 1; v.lload = 63;
        run(v);
        chk("rs.len1_en", int'(o_en), 1);
        cyc(1, 0);
        chk("rs.step0_en", int'(o_en), 0);

        // random traffic against the model
        base = idle();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                base.duty = $urandom_range(0, 3);
                base.len_en = $urandom_range(0, 1);
                base.einit = $urandom_range(0, 15);
                base.eup = $urandom_range(0, 1);
                base.eper = $urandom_range(0, 7);
                base.sper = $urandom_range(0, 7);
                base.sdown = $urandom_range(0, 1);
                base.sshift = $urandom_range(0, 7);
            end
            v = base;
            v.rst = ($urandom_range(0, 499) == 0);
            v.tick = ($urandom_range(0, 2) == 0);
            v.trig = ($urandom_range(0, 39) == 0);
            v.fwr = !v.trig && ($urandom_range(0, 29) == 0);
            v.freq = $urandom_range(0, 2047);
            v.lwr = ($urandom_range(0, 24) == 0);
            v.lload = $urandom_range(0, 63);
            run(v);
            chk_all("rnd", m_freq, m_duty, m_vol, int'(m_en));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
